// File: rtl/fpga_prog_ctrl.sv
// Configuration-chain sequencer: streams bitstream words LSB-first into the fabric
// chain, generating prog_clk/prog_en, with optional read-back compare on prog_out.
module fpga_prog_ctrl #(
    parameter int CHAIN_LEN = 1480,
    parameter int WORD_W    = 32,
    parameter int CLK_DIV   = 1,
    parameter int IDX_W     = $clog2(CHAIN_LEN)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              verify_en,
    input  logic [WORD_W-1:0] word_data,
    input  logic [WORD_W-1:0] word_exp,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              prog_in,
    output logic              prog_clk,
    output logic              prog_en,
    input  logic              prog_out,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              error,
    output logic [IDX_W-1:0]  err_idx
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WAIT   = 3'd1;
    localparam logic [2:0] ST_SETUP  = 3'd2;
    localparam logic [2:0] ST_HIGH   = 3'd3;
    localparam logic [2:0] ST_FINISH = 3'd4;

    localparam int WB_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(CHAIN_LEN - 1);
    localparam logic [WB_W-1:0]  LAST_WBIT = WB_W'(WORD_W - 1);
    localparam logic [DIV_W-1:0] LAST_DIV  = DIV_W'(CLK_DIV - 1);

    logic [2:0]        state_q, state_d;
    logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic [WB_W-1:0]   wbit_q, wbit_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [WORD_W-1:0] expreg_q, expreg_d;
    logic              verify_q, verify_d;
    logic              error_q, error_d;
    logic [IDX_W-1:0]  err_idx_q, err_idx_d;
    logic              prog_in_q, prog_in_d;
    logic              prog_clk_q, prog_clk_d;
    logic              prog_en_q, prog_en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              aborted_q, aborted_d;

    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        wbit_d     = wbit_q;
        div_d      = div_q;
        shreg_d    = shreg_q;
        expreg_d   = expreg_q;
        verify_d   = verify_q;
        error_d    = error_q;
        err_idx_d  = err_idx_q;
        prog_in_d  = prog_in_q;
        prog_clk_d = prog_clk_q;
        prog_en_d  = prog_en_q;
        done_d     = 1'b0;
        aborted_d  = 1'b0;

        if (state_q != ST_IDLE && abort) begin
            state_d    = ST_IDLE;
            aborted_d  = 1'b1;
            prog_en_d  = 1'b0;
            prog_clk_d = 1'b0;
            prog_in_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && !abort) begin
                        state_d    = ST_WAIT;
                        verify_d   = verify_en;
                        error_d    = 1'b0;
                        err_idx_d  = '0;
                        bit_idx_d  = '0;
                        prog_en_d  = 1'b1;
                        prog_clk_d = 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (word_valid) begin
                        shreg_d   = word_data;
                        expreg_d  = word_exp;
                        wbit_d    = '0;
                        div_d     = '0;
                        prog_in_d = word_data[0];
                        state_d   = ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    // prog_out still holds the pre-shift tail during the first setup cycle
                    if (div_q == '0 && verify_q && !error_q && (prog_out != expreg_q[0])) begin
                        error_d   = 1'b1;
                        err_idx_d = bit_idx_q;
                    end
                    if (div_q == LAST_DIV) begin
                        div_d      = '0;
                        prog_clk_d = 1'b1;
                        state_d    = ST_HIGH;
                    end else begin
                        div_d = div_q + DIV_W'(1);
                    end
                end
                ST_HIGH: begin
                    if (div_q == LAST_DIV) begin
                        div_d      = '0;
                        prog_clk_d = 1'b0;
                        if (bit_idx_q == LAST_BIT) begin
                            state_d = ST_FINISH;
                        end else begin
                            bit_idx_d = bit_idx_q + IDX_W'(1);
                            if (wbit_q == LAST_WBIT) begin
                                state_d = ST_WAIT;
                            end else begin
                                shreg_d   = shreg_q >> 1;
                                expreg_d  = expreg_q >> 1;
                                wbit_d    = wbit_q + WB_W'(1);
                                prog_in_d = shreg_d[0];
                                state_d   = ST_SETUP;
                            end
                        end
                    end else begin
                        div_d = div_q + DIV_W'(1);
                    end
                end
                ST_FINISH: begin
                    state_d    = ST_IDLE;
                    done_d     = 1'b1;
                    prog_en_d  = 1'b0;
                    prog_clk_d = 1'b0;
                    prog_in_d  = 1'b0;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            bit_idx_q  <= '0;
            wbit_q     <= '0;
            div_q      <= '0;
            shreg_q    <= '0;
            expreg_q   <= '0;
            verify_q   <= 1'b0;
            error_q    <= 1'b0;
            err_idx_q  <= '0;
            prog_in_q  <= 1'b0;
            prog_clk_q <= 1'b0;
            prog_en_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_idx_q  <= bit_idx_d;
            wbit_q     <= wbit_d;
            div_q      <= div_d;
            shreg_q    <= shreg_d;
            expreg_q   <= expreg_d;
            verify_q   <= verify_d;
            error_q    <= error_d;
            err_idx_q  <= err_idx_d;
            prog_in_q  <= prog_in_d;
            prog_clk_q <= prog_clk_d;
            prog_en_q  <= prog_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            aborted_q  <= aborted_d;
        end
    end

    assign word_ready = (state_q == ST_WAIT);
    assign prog_in    = prog_in_q;
    assign prog_clk   = prog_clk_q;
    assign prog_en    = prog_en_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign aborted    = aborted_q;
    assign error      = error_q;
    assign err_idx    = err_idx_q;

endmodule

// File: tb/tb_fpga_prog_ctrl.sv
// Bench for fpga_prog_ctrl: four parameterisations, each with a shift-register model
// of the fabric chain; directed runs with hand-computed expected chain contents.
module tb_fpga_prog_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, abort, verify_en, word_valid, ld_v;
    logic [31:0] word_data, word_exp;
    logic [3:0]  start_v, rdy, pin, pclk, pen, bsy, dn, ab, err, pout;
    logic [10:0] eidx_def;
    logic [2:0]  eidx_d2, eidx_v;
    logic [3:0]  eidx_t;

    logic [1479:0] chain_def, exp_bits;
    logic [7:0]    chain_d2, chain_v, preset_v;
    logic [9:0]    chain_t;
    logic [3:0]    pclk_prev;
    int            rises[4];
    logic [31:0]   words[64];
    logic [31:0]   exps[64];

    int checks, errors;
    int r_done_cyc, r_abort_cyc, r_abort_lat, r_rises, r_stall_cnt;
    bit r_late, r_stall_bad, r_extra_done, r_err_at_start, r_busy_done, r_start_ok, r_pen_ab, r_pclk_ab;

    assign pout[0] = chain_def[0];
    assign pout[1] = chain_d2[0];
    assign pout[2] = chain_v[0];
    assign pout[3] = chain_t[0];

    fpga_prog_ctrl #(.CHAIN_LEN(1480), .WORD_W(32), .CLK_DIV(1)) u_def (
        .clk(clk), .reset(reset), .start(start_v[0]), .abort(abort), .verify_en(verify_en),
        .word_data(word_data), .word_exp(word_exp), .word_valid(word_valid), .word_ready(rdy[0]),
        .prog_in(pin[0]), .prog_clk(pclk[0]), .prog_en(pen[0]), .prog_out(pout[0]), .busy(bsy[0]),
        .done(dn[0]), .aborted(ab[0]), .error(err[0]), .err_idx(eidx_def));

    fpga_prog_ctrl #(.CHAIN_LEN(8), .WORD_W(4), .CLK_DIV(2)) u_d2 (
        .clk(clk), .reset(reset), .start(start_v[1]), .abort(abort), .verify_en(verify_en),
        .word_data(word_data[3:0]), .word_exp(word_exp[3:0]), .word_valid(word_valid), .word_ready(rdy[1]),
        .prog_in(pin[1]), .prog_clk(pclk[1]), .prog_en(pen[1]), .prog_out(pout[1]), .busy(bsy[1]),
        .done(dn[1]), .aborted(ab[1]), .error(err[1]), .err_idx(eidx_d2));

    fpga_prog_ctrl #(.CHAIN_LEN(8), .WORD_W(4), .CLK_DIV(1)) u_v (
        .clk(clk), .reset(reset), .start(start_v[2]), .abort(abort), .verify_en(verify_en),
        .word_data(word_data[3:0]), .word_exp(word_exp[3:0]), .word_valid(word_valid), .word_ready(rdy[2]),
        .prog_in(pin[2]), .prog_clk(pclk[2]), .prog_en(pen[2]), .prog_out(pout[2]), .busy(bsy[2]),
        .done(dn[2]), .aborted(ab[2]), .error(err[2]), .err_idx(eidx_v));

    fpga_prog_ctrl #(.CHAIN_LEN(10), .WORD_W(4), .CLK_DIV(1)) u_t (
        .clk(clk), .reset(reset), .start(start_v[3]), .abort(abort), .verify_en(verify_en),
        .word_data(word_data[3:0]), .word_exp(word_exp[3:0]), .word_valid(word_valid), .word_ready(rdy[3]),
        .prog_in(pin[3]), .prog_clk(pclk[3]), .prog_en(pen[3]), .prog_out(pout[3]), .busy(bsy[3]),
        .done(dn[3]), .aborted(ab[3]), .error(err[3]), .err_idx(eidx_t));

    // Fabric chains: new bit enters at the top, tail (prog_out) is bit 0, so after a
    // full run chain[k] holds stream bit k.
    always @(posedge clk) begin
        pclk_prev <= pclk;
        for (int i = 0; i < 4; i++)
            if (pclk[i] && !pclk_prev[i]) rises[i] <= rises[i] + 1;
        if (pclk[0] && !pclk_prev[0]) chain_def <= {pin[0], chain_def[1479:1]};
        if (pclk[1] && !pclk_prev[1]) chain_d2 <= {pin[1], chain_d2[7:1]};
        if (ld_v) chain_v <= preset_v;
        else if (pclk[2] && !pclk_prev[2]) chain_v <= {pin[2], chain_v[7:1]};
        if (pclk[3] && !pclk_prev[3]) chain_t <= {pin[3], chain_t[9:1]};
    end

    task automatic run(input int inst, input int nwords, input int stall_word, input int stall_len,
                       input int start_again, input int abort_bits, input int budget);
        int ptr, c, hs, r0, abort_set;
        bit abort_sent;
        ptr = 0; hs = 0; abort_set = -1; abort_sent = 0;
        r_done_cyc = -1; r_abort_cyc = -1; r_abort_lat = -1; r_stall_cnt = 0;
        r_late = 0; r_stall_bad = 0; r_extra_done = 0; r_busy_done = 1; r_pen_ab = 1; r_pclk_ab = 1;
        r0 = rises[inst];
        @(negedge clk);
        start_v[inst] = 1'b1;
        word_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        c = 1;
        start_v[inst] = 1'b0;
        r_err_at_start = err[inst];
        r_start_ok = pen[inst] && rdy[inst];
        while (c <= budget && r_done_cyc < 0 && r_abort_cyc < 0) begin
            start_v[inst] = (c == start_again);
            abort = 1'b0;
            if (abort_bits > 0 && !abort_sent && (rises[inst] - r0) >= abort_bits) begin
                abort = 1'b1;
                abort_sent = 1'b1;
                abort_set = c;
            end
            word_data = words[ptr];
            word_exp = exps[ptr];
            word_valid = !(ptr == stall_word && r_stall_cnt < stall_len);
            if (rdy[inst]) begin
                if (hs >= nwords) r_late = 1'b1;
                if (!word_valid) begin
                    r_stall_cnt++;
                    if (pclk[inst] || !pen[inst]) r_stall_bad = 1'b1;
                end else begin
                    hs++;
                    ptr++;
                end
            end
            @(posedge clk);
            @(negedge clk);
            c++;
            if (dn[inst]) begin
                r_done_cyc = c;
                r_busy_done = bsy[inst];
            end
            if (ab[inst]) begin
                r_abort_cyc = c;
                r_pen_ab = pen[inst];
                r_pclk_ab = pclk[inst];
            end
        end
        abort = 1'b0;
        start_v[inst] = 1'b0;
        word_valid = 1'b0;
        if (abort_set >= 0 && r_abort_cyc >= 0) r_abort_lat = r_abort_cyc - abort_set;
        if (r_done_cyc > 0) begin
            repeat (3) begin
                @(posedge clk);
                @(negedge clk);
                if (dn[inst]) r_extra_done = 1'b1;
            end
        end
        r_rises = rises[inst] - r0;
    endtask

    task automatic load_v(input logic [7:0] val);
        @(negedge clk);
        preset_v = val;
        ld_v = 1'b1;
        @(negedge clk);
        ld_v = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({pin[i], pclk[i], pen[i], rdy[i], bsy[i], dn[i], ab[i], err[i]} !== 8'h00) begin
                errors++;
                $display("FAIL reset_outputs[%0d]: got %b required 00000000", i,
                         {pin[i], pclk[i], pen[i], rdy[i], bsy[i], dn[i], ab[i], err[i]});
            end
        end
        checks++;
        if ({eidx_def, eidx_d2, eidx_v, eidx_t} !== 21'd0) begin
            errors++;
            $display("FAIL reset_err_idx: got %h required 0", {eidx_def, eidx_d2, eidx_v, eidx_t});
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_default_run();
        logic [31:0] w;
        int diff;
        for (int i = 0; i < 47; i++) begin
            words[i] = $urandom;
            exps[i] = '0;
        end
        for (int b = 0; b < 1480; b++) begin
            w = words[b / 32];
            exp_bits[b] = w[b % 32];
        end
        verify_en = 1'b0;
        run(0, 47, -1, 0, -1, 0, 4000);
        checks++;
        if (r_start_ok !== 1'b1) begin errors++; $display("FAIL def_start_outputs: got %0d required 1", r_start_ok); end
        checks++;
        if (r_done_cyc !== 3009) begin errors++; $display("FAIL def_done_cycle: got %0d required 3009", r_done_cyc); end
        checks++;
        if (r_rises !== 1480) begin errors++; $display("FAIL def_rises: got %0d required 1480", r_rises); end
        diff = 0;
        for (int b = 0; b < 1480; b++) if (chain_def[b] !== exp_bits[b]) diff++;
        checks++;
        if (diff !== 0) begin errors++; $display("FAIL def_chain: differing bits got %0d required 0", diff); end
        checks++;
        if ({r_late, r_extra_done, r_busy_done} !== 3'b000) begin
            errors++;
            $display("FAIL def_late_ready_extra_done_busy: got %b required 000", {r_late, r_extra_done, r_busy_done});
        end
    endtask

    task automatic test_reset_mid_run();
        bit found;
        @(negedge clk);
        start_v[1] = 1'b1;
        word_data = 32'h9;
        word_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v[1] = 1'b0;
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (pclk[1]) found = 1;
            else begin
                @(posedge clk);
                @(negedge clk);
            end
        end
        checks++;
        if (found !== 1'b1) begin errors++; $display("FAIL rst_reach_high: got %0d required 1", found); end
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({pin[1], pclk[1], pen[1], rdy[1], bsy[1], dn[1], ab[1], err[1], eidx_d2} !== 11'd0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got %b required 0", {pin[1], pclk[1], pen[1], rdy[1], bsy[1], dn[1], ab[1], err[1], eidx_d2});
        end
        reset = 1'b1;
        word_valid = 1'b0;
        words[0] = 32'h9;
        words[1] = 32'h6;
        verify_en = 1'b0;
        run(1, 2, -1, 0, -1, 0, 100);
        checks++;
        if (r_done_cyc !== 36) begin errors++; $display("FAIL rst_rerun_done_cycle: got %0d required 36", r_done_cyc); end
        checks++;
        if (r_rises !== 8) begin errors++; $display("FAIL rst_rerun_rises: got %0d required 8", r_rises); end
        checks++;
        if (chain_d2 !== 8'h69) begin errors++; $display("FAIL rst_rerun_chain: got %h required 69", chain_d2); end
    endtask

    task automatic test_verify();
        words[0] = 32'hA; words[1] = 32'h5;
        exps[0] = 32'hC; exps[1] = 32'h3;
        verify_en = 1'b1;
        load_v(8'h7C);
        run(2, 2, -1, 0, -1, 0, 60);
        checks++;
        if (r_done_cyc !== 20) begin errors++; $display("FAIL vfy_bad_done_cycle: got %0d required 20", r_done_cyc); end
        checks++;
        if ({err[2], eidx_v} !== {1'b1, 3'd6}) begin
            errors++; $display("FAIL vfy_bad_error: got err=%0d idx=%0d required err=1 idx=6", err[2], eidx_v);
        end
        checks++;
        if (chain_v !== 8'h5A || r_rises !== 8) begin
            errors++; $display("FAIL vfy_bad_chain: got %h rises %0d required 5a rises 8", chain_v, r_rises);
        end
        load_v(8'h3C);
        run(2, 2, -1, 0, -1, 0, 60);
        checks++;
        if (r_err_at_start !== 1'b0) begin errors++; $display("FAIL vfy_error_clear_on_start: got %0d required 0", r_err_at_start); end
        checks++;
        if (r_done_cyc !== 20 || err[2] !== 1'b0) begin
            errors++; $display("FAIL vfy_good: got done=%0d err=%0d required done=20 err=0", r_done_cyc, err[2]);
        end
        checks++;
        if (chain_v !== 8'h5A) begin errors++; $display("FAIL vfy_good_chain: got %h required 5a", chain_v); end
    endtask

    task automatic test_truncate();
        words[0] = 32'h3; words[1] = 32'hC; words[2] = 32'hF;
        verify_en = 1'b0;
        run(3, 3, -1, 0, -1, 0, 60);
        checks++;
        if (r_done_cyc !== 25) begin errors++; $display("FAIL trunc_done_cycle: got %0d required 25", r_done_cyc); end
        checks++;
        if (r_rises !== 10) begin errors++; $display("FAIL trunc_rises: got %0d required 10", r_rises); end
        checks++;
        if (chain_t !== 10'h3C3) begin errors++; $display("FAIL trunc_chain: got %h required 3c3", chain_t); end
        checks++;
        if (r_late !== 1'b0) begin errors++; $display("FAIL trunc_ready_after_last: got %0d required 0", r_late); end
    endtask

    task automatic test_stall_and_start();
        words[0] = 32'hA; words[1] = 32'h5;
        verify_en = 1'b0;
        run(2, 2, 1, 20, 6, 0, 100);
        checks++;
        if (r_stall_cnt !== 20 || r_stall_bad !== 1'b0) begin
            errors++; $display("FAIL stall_outputs: got cnt=%0d bad=%0d required cnt=20 bad=0", r_stall_cnt, r_stall_bad);
        end
        checks++;
        if (r_done_cyc !== 40) begin errors++; $display("FAIL stall_done_cycle: got %0d required 40", r_done_cyc); end
        checks++;
        if (chain_v !== 8'h5A || r_rises !== 8 || r_extra_done !== 1'b0) begin
            errors++; $display("FAIL stall_chain: got %h rises %0d extra %0d required 5a rises 8 extra 0", chain_v, r_rises, r_extra_done);
        end
    endtask

    task automatic test_abort();
        words[0] = 32'hA; words[1] = 32'h5;
        exps[0] = 32'hC; exps[1] = 32'h3;
        verify_en = 1'b1;
        load_v(8'h38);
        run(2, 2, -1, 0, -1, 5, 60);
        checks++;
        if (r_abort_lat !== 1) begin errors++; $display("FAIL abort_latency: got %0d required 1", r_abort_lat); end
        checks++;
        if ({r_pen_ab, r_pclk_ab, bsy[2]} !== 3'b000) begin
            errors++; $display("FAIL abort_outputs: got %b required 000", {r_pen_ab, r_pclk_ab, bsy[2]});
        end
        checks++;
        if ({err[2], eidx_v} !== {1'b1, 3'd2}) begin
            errors++; $display("FAIL abort_error_kept: got err=%0d idx=%0d required err=1 idx=2", err[2], eidx_v);
        end
        checks++;
        if (r_done_cyc !== -1) begin errors++; $display("FAIL abort_no_done: got %0d required -1", r_done_cyc); end
    endtask

    task automatic test_back_to_back();
        words[0] = 32'h5; words[1] = 32'hA;
        verify_en = 1'b0;
        run(2, 2, -1, 0, -1, 0, 60);
        checks++;
        if (r_done_cyc !== 20 || chain_v !== 8'hA5) begin
            errors++; $display("FAIL b2b_run: got done=%0d chain=%h required done=20 chain=a5", r_done_cyc, chain_v);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0;
        reset = 1'b0; abort = 1'b0; verify_en = 1'b0; word_valid = 1'b0; ld_v = 1'b0;
        word_data = '0; word_exp = '0; start_v = '0; preset_v = '0;
        for (int i = 0; i < 64; i++) begin
            words[i] = '0;
            exps[i] = '0;
        end
        test_reset();
        test_default_run();
        test_reset_mid_run();
        test_verify();
        test_truncate();
        test_stall_and_start();
        test_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
